// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared states, register map and step width for the setpoint controller
package pwm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PEND, RAMP} state_t;
  localparam int STEPW       = 16;
  localparam int ADDR_STAGE0 = 0;
  localparam int ADDR_STAGE1 = 1;
  localparam int ADDR_STAGE2 = 2;
  localparam int ADDR_COMMIT = 3;
  localparam int ADDR_STEP0  = 4;
  localparam int ADDR_STEP1  = 5;
  localparam int ADDR_ABORT  = 6;
endpackage

// File: rtl/pwm_slew_step.sv
// pwm_slew_step: next compare value one slew step toward target, never overshooting or wrapping
module pwm_slew_step
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] target,
  input  logic [STEPW-1:0] step,
  output logic [WIDTH-1:0] next,
  output logic             reached
);
  logic             up;
  logic [WIDTH:0]   d;
  logic [WIDTH-1:0] s;
  // the distance is checked before stepping, so cur+s / cur-s can never pass target or wrap
  always_comb begin
    up      = target > cur;
    d       = up ? {1'b0, target} - {1'b0, cur} : {1'b0, cur} - {1'b0, target};
    s       = WIDTH'(step);
    reached = (step == '0) || (d <= {1'b0, s});
    next    = reached ? target : up ? cur + s : cur - s;
  end
endmodule

// File: rtl/pwm_setpoint_ctrl.sv
// pwm_setpoint_ctrl: stages register writes and moves the live PWM compare value on period boundaries
module pwm_setpoint_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 20,
  parameter int               REGBITS     = 3,
  parameter logic [WIDTH-1:0] RESET_CMP   = 20'hA0002,
  parameter logic [WIDTH-1:0] RESET_STAGE = 20'h01342,
  parameter logic [STEPW-1:0] RESET_STEP  = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REGBITS-1:0] reg_addr,
  input  logic [7:0]         reg_data,
  input  logic               reg_valid,
  input  logic               period_tick,
  output logic [WIDTH-1:0]   cmp_out,
  output logic               cmp_update,
  output logic               busy,
  output logic               done
);
  state_t           state;
  logic [WIDTH-1:0] target, stage, next;
  logic [STEPW-1:0] step;
  logic             reached;
  logic             commit, abort;

  assign commit = reg_valid && reg_addr == REGBITS'(ADDR_COMMIT);
  assign abort  = reg_valid && reg_addr == REGBITS'(ADDR_ABORT);

  pwm_slew_step #(.WIDTH(WIDTH)) u_slew (
    .cur(cmp_out),
    .target(target),
    .step(step),
    .next(next),
    .reached(reached)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_out    <= RESET_CMP;
      target     <= RESET_CMP;
      stage      <= RESET_STAGE;
      step       <= RESET_STEP;
      state      <= IDLE;
      busy       <= 1'b0;
      cmp_update <= 1'b0;
      done       <= 1'b0;
    end else begin
      cmp_update <= 1'b0;
      done       <= 1'b0;
      if (reg_valid && reg_addr == REGBITS'(ADDR_STAGE0)) stage[7:0] <= reg_data;
      if (reg_valid && reg_addr == REGBITS'(ADDR_STAGE1)) stage[15:8] <= reg_data;
      if (reg_valid && reg_addr == REGBITS'(ADDR_STAGE2)) stage[WIDTH-1:16] <= reg_data[WIDTH-17:0];
      if (reg_valid && reg_addr == REGBITS'(ADDR_STEP0)) step[7:0] <= reg_data;
      if (reg_valid && reg_addr == REGBITS'(ADDR_STEP1)) step[15:8] <= reg_data;
      // a commit swallows any coincident tick so the first move lands on the next period
      if (commit) begin
        target <= stage;
        state  <= stage == cmp_out ? IDLE : step == '0 ? PEND : RAMP;
        busy   <= stage != cmp_out;
        done   <= stage == cmp_out;
      end else if (abort && state != IDLE) begin
        target <= cmp_out;
        state  <= IDLE;
        busy   <= 1'b0;
      end else if (period_tick && state != IDLE) begin
        cmp_out    <= state == PEND ? target : next;
        cmp_update <= 1'b1;
        if (state == PEND || reached) begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/pwm_setpoint_ctrl.md
Name: pwm_setpoint_ctrl

Overview:
Sequences compare-value updates into the PWM datapath. It collects byte writes from the I2C register interface into a staging register. On a commit write, it moves the live compare value to the new target. The move is either a single jump or a slew-limited ramp, and the live value only changes at PWM period boundaries so that no period is ever truncated or glitched. It sits between the I2C register interface and the PWM core, on the PWM core's slow clock domain.

Parameters:
WIDTH, 20, compare value width (17..24)
REGBITS, 3, register address width
RESET_CMP, 20'hA0002, live compare value after reset
RESET_STAGE, 20'h01342, staging value after reset
RESET_STEP, 16'h0000, ramp step after reset (0 = jump)

Ports:
clk  in  1  PWM core clock (divided DDR sclk)
rst  in  1  synchronous active-high reset
reg_addr  in  REGBITS  register address from I2C interface
reg_data  in  8  write data byte
reg_valid  in  1  one-cycle write strobe
period_tick  in  1  one-cycle pulse at PWM period start, from PWM core
cmp_out  out  WIDTH  live compare value to PWM core
cmp_update  out  1  one-cycle pulse whenever cmp_out changes
busy  out  1  high while in PEND or RAMP
done  out  1  one-cycle pulse when cmp_out reaches target

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - cmp_out=RESET_CMP, target=RESET_CMP, stage=RESET_STAGE, step=RESET_STEP
  - state=IDLE; busy=0, cmp_update=0, done=0
- Register map (write-only, acted on when reg_valid=1):
  - 0: stage[7:0]
  - 1: stage[15:8]
  - 2: stage[WIDTH-1:16]; unused upper data bits ignored
  - 3: commit; data ignored
  - 4: step[7:0]
  - 5: step[15:8]
  - 6: abort; data ignored
  - 7: no effect
- Commit (addr 3):
  - target<=stage
  - step==0 -> state PEND; otherwise -> state RAMP
  - If target already equals cmp_out: state IDLE, done pulses next cycle, no cmp_update.
- IDLE: cmp_out holds; period_tick ignored.
- PEND, on period_tick:
  - cmp_out<=target; cmp_update=1 and done=1 in the following cycle; -> IDLE
- RAMP, on period_tick:
  - d = |target-cmp_out|, computed in WIDTH+1 bits
  - d<=step -> cmp_out<=target, done pulse, -> IDLE
  - else cmp_out moves step toward target (unsigned, no wrap: never overshoots, never crosses 0 or 2^WIDTH-1)
  - cmp_update pulses on every change
- Latency:
  - cmp_out changes exactly 1 clk after the qualifying period_tick edge
  - busy rises 1 clk after the commit strobe
- Simultaneous commit and period_tick in the same cycle:
  - The commit wins; the tick is not consumed.
  - The first step or jump occurs on the next period_tick.
- Commit while PEND or RAMP:
  - Retargets; the ramp continues from the current cmp_out.
  - The mode is re-chosen from the current step.
- Step writes during RAMP take effect at the next tick.
- Stage writes during PEND or RAMP do not affect target until the next commit.
- Abort (addr 6): target<=cmp_out, -> IDLE, no done pulse, cmp_out unchanged. Abort in IDLE has no effect.
- Reset asserted mid-ramp: everything returns to reset values in the next cycle; any pending tick is discarded.
- cmp_update and done never assert while rst=1.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - state enum {IDLE, PEND, RAMP}
  - register address constants (ADDR_STAGE0..2, ADDR_COMMIT, ADDR_STEP0..1, ADDR_ABORT)
  - STEPW=16
- One sub-module, pwm_slew_step: combinational next-value calculation (cur, target, step -> next, reached).
  - Tested standalone for the saturation and no-overshoot rules.

Test Plan:
- Reset, then 3 period_ticks -> cmp_out=20'hA0002, busy=0, no cmp_update.
- Write stage bytes 0x34,0x12,0x05 with step 0, commit, tick -> cmp_out=20'h51234 one clk after the tick; single cmp_update and done; busy 1->0.
- step=0x4000, stage=20'hA8002, commit -> across 2 ticks: 20'hA4002, then 20'hA8002 with done; moving down to 20'h9E002 in the same way ends exactly on target with no overshoot.
- Commit in the same cycle as period_tick -> cmp_out unchanged at that tick, first step at the following tick.
- Mid-ramp, commit a new stage below cmp_out -> ramp reverses direction from the current value; mid-ramp abort -> IDLE, cmp_out frozen, no done.
- Assert rst for 1 cycle mid-ramp -> cmp_out=20'hA0002, step=0, state IDLE next cycle; subsequent ticks produce no change.
